// File: rtl/result_acc_ram.sv
// Dual-port result buffer with saturating accumulate on port 0,
// a self-running clear engine and a sticky overflow flag.
module result_acc_ram #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 4,
  parameter int MEM_SIZE = 16,
  parameter bit SAT      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              busy,
  output logic              ovf,
  input  logic              ce0,
  input  logic [1:0]        op0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] d0,
  output logic [DWIDTH-1:0] q0,
  output logic              q0_valid,
  input  logic              ce1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] d1,
  output logic [DWIDTH-1:0] q1,
  output logic              q1_valid
);

  localparam logic [AWIDTH:0]   MSZ  = (AWIDTH+1)'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(MEM_SIZE-1);
  localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              clr_go, act;

  logic [DWIDTH-1:0] mem_q [MEM_SIZE];

  logic              acc_v_q, acc_v_d;
  logic [AWIDTH-1:0] acc_addr_q, acc_addr_d;
  logic [DWIDTH-1:0] acc_old_q, acc_old_d;
  logic [DWIDTH-1:0] acc_add_q, acc_add_d;

  logic [DWIDTH:0]   sum;
  logic              acc_ovf, wb_v, wb_we;
  logic [DWIDTH-1:0] acc_res;

  logic              p0_rd, p0_wr, p0_acc, p1_rd, p1_wr;
  logic              in0, in1, in_acc;
  logic [DWIDTH-1:0] rd0, rd1;

  logic [DWIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
  logic              q0v_q, q0v_d, q1v_q, q1v_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + AWIDTH'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_CLEAR);
    clr_go = (state_q == S_IDLE) && clr_start;
    act    = (state_q == S_IDLE) && !clr_start;
  end

  always_comb begin
    in0    = {1'b0, addr0} < MSZ;
    in1    = {1'b0, addr1} < MSZ;
    in_acc = {1'b0, acc_addr_q} < MSZ;
    p0_rd  = 1'b0;
    p0_wr  = 1'b0;
    p0_acc = 1'b0;
    if (act && ce0) begin
      unique case (1'b1)
        op0 == 2'b00: p0_rd  = 1'b1;
        op0 == 2'b01: p0_wr  = 1'b1;
        op0 == 2'b10: p0_acc = 1'b1;
        default: ;
      endcase
    end
    p1_rd = act && ce1 && !we1;
    p1_wr = act && ce1 && we1;
  end

  // Signed sum one bit wider than the data so overflow is exact.
  always_comb begin
    sum = {acc_old_q[DWIDTH-1], acc_old_q}
        + {acc_add_q[DWIDTH-1], acc_add_q};
    acc_ovf = sum[DWIDTH] ^ sum[DWIDTH-1];
    acc_res = sum[DWIDTH-1:0];
    if (SAT && acc_ovf)
      acc_res = sum[DWIDTH] ? MINV : MAXV;
    wb_v  = acc_v_q && !clr_go;
    wb_we = wb_v && in_acc;
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (in0)
      rd0 = (acc_v_q && addr0 == acc_addr_q) ? acc_res : mem_q[addr0];
    if (in1)
      rd1 = (acc_v_q && addr1 == acc_addr_q) ? acc_res : mem_q[addr1];
  end

  always_comb begin
    acc_v_d    = p0_acc;
    acc_addr_d = p0_acc ? addr0 : acc_addr_q;
    acc_old_d  = p0_acc ? rd0 : acc_old_q;
    acc_add_d  = p0_acc ? d0 : acc_add_q;
    q0v_d      = p0_rd;
    q0_d       = p0_rd ? rd0 : q0_q;
    q1v_d      = p1_rd;
    q1_d       = p1_rd ? rd1 : q1_q;
    ovf_d      = clr_go ? 1'b0 : (ovf_q | (wb_v && acc_ovf));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_v_q    <= 1'b0;
      acc_addr_q <= '0;
      acc_old_q  <= '0;
      acc_add_q  <= '0;
      q0_q       <= '0;
      q0v_q      <= 1'b0;
      q1_q       <= '0;
      q1v_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      acc_v_q    <= acc_v_d;
      acc_addr_q <= acc_addr_d;
      acc_old_q  <= acc_old_d;
      acc_add_q  <= acc_add_d;
      q0_q       <= q0_d;
      q0v_q      <= q0v_d;
      q1_q       <= q1_d;
      q1v_q      <= q1v_d;
      ovf_q      <= ovf_d;
    end
  end

  // Later assignments win: write-back over port 0 over port 1.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (p1_wr && in1) mem_q[addr1] <= d1;
      if (p0_wr && in0) mem_q[addr0] <= d0;
      if (wb_we) mem_q[acc_addr_q] <= acc_res;
    end
  end

  assign q0       = q0_q;
  assign q0_valid = q0v_q;
  assign q1       = q1_q;
  assign q1_valid = q1v_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_result_acc_ram.sv
// Scoreboard bench for result_acc_ram: saturating and wrapping
// instances driven in lockstep, monitor pops expected reads.
module tb_result_acc_ram;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_start = 1'b0;
  logic          ce0 = 1'b0, ce1 = 1'b0, we1 = 1'b0;
  logic [1:0]    op0 = 2'b00;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          busy, ovf, q0_valid, q1_valid;
  logic [DW-1:0] q0, q1;
  logic          w_busy, w_ovf, w_q0v, w_q1v;
  logic [DW-1:0] w_q0, w_q1;

  int errors = 0;
  int checks = 0;
  int n;

  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  logic [DW-1:0] expw[$];

  result_acc_ram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start),
    .busy(busy), .ovf(ovf),
    .ce0(ce0), .op0(op0), .addr0(addr0), .d0(d0),
    .q0(q0), .q0_valid(q0_valid),
    .ce1(ce1), .we1(we1), .addr1(addr1), .d1(d1),
    .q1(q1), .q1_valid(q1_valid)
  );

  result_acc_ram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start),
    .busy(w_busy), .ovf(w_ovf),
    .ce0(ce0), .op0(op0), .addr0(addr0), .d0(d0),
    .q0(w_q0), .q0_valid(w_q0v),
    .ce1(ce1), .we1(we1), .addr1(addr1), .d1(d1),
    .q1(w_q1), .q1_valid(w_q1v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [DW-1:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected valid, got %h expected none", name, act);
  endtask

  always @(negedge clk) begin
    if (q0_valid) begin
      if (exp0.size() == 0) unexpected("q0", q0);
      else chk("q0", q0, exp0.pop_front());
    end
    if (q1_valid) begin
      if (exp1.size() == 0) unexpected("q1", q1);
      else chk("q1", q1, exp1.pop_front());
    end
    if (w_q0v) begin
      if (expw.size() == 0) unexpected("wrap q0", w_q0);
      else chk("wrap q0", w_q0, expw.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ce0 = 1'b0;
    ce1 = 1'b0;
    we1 = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic step();
    tick();
    idle_all();
  endtask

  task automatic set_rd0(input int a, input logic [DW-1:0] e,
                         input logic [DW-1:0] ew);
    ce0 = 1'b1; op0 = 2'b00; addr0 = AW'(a);
    exp0.push_back(e);
    expw.push_back(ew);
  endtask

  task automatic set_wr0(input int a, input logic [DW-1:0] d);
    ce0 = 1'b1; op0 = 2'b01; addr0 = AW'(a); d0 = d;
  endtask

  task automatic set_acc0(input int a, input logic [DW-1:0] d);
    ce0 = 1'b1; op0 = 2'b10; addr0 = AW'(a); d0 = d;
  endtask

  task automatic set_rd1(input int a, input logic [DW-1:0] e);
    ce1 = 1'b1; we1 = 1'b0; addr1 = AW'(a);
    exp1.push_back(e);
  endtask

  task automatic set_wr1(input int a, input logic [DW-1:0] d);
    ce1 = 1'b1; we1 = 1'b1; addr1 = AW'(a); d1 = d;
  endtask

  // Counts edges until busy drops; optionally pokes ports and
  // clr_start once mid-clear, which must all be ignored.
  task automatic count_busy(input int pulse_at, output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      if (cnt == pulse_at) begin
        clr_start = 1'b1;
        ce0 = 1'b1; op0 = 2'b00; addr0 = '0;
        ce1 = 1'b1; we1 = 1'b0; addr1 = '0;
      end else begin
        idle_all();
      end
      tick();
      cnt++;
    end
    idle_all();
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < MS; a++) begin
      set_rd0(a, '0, '0);
      set_rd1(a, '0);
      step();
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset busy", busy, 1);
    chk("reset ovf", ovf, 0);
    chk("reset q0", q0, 0);
    chk("reset q1", q1, 0);
    chk("reset q0_valid", q0_valid, 0);
    chk("reset q1_valid", q1_valid, 0);
    rst_n = 1'b1;
    count_busy(-1, n);
    chk("busy cycles after reset", n, 16);

    for (int a = 0; a < MS; a++) begin
      set_rd1(a, '0);
      step();
    end
    step();
    chk("ovf after init", ovf, 0);

    set_acc0(3, 32'd5); step();
    set_acc0(3, 32'd7); step();
    set_acc0(3, 32'hFFFF_FFFE); step();
    set_rd0(3, 32'd10, 32'd10); step();
    step();
    chk("q0 hold value", q0, 32'd10);
    chk("q0_valid drops", q0_valid, 0);

    set_wr0(7, 32'h7FFF_FFF0); step();
    set_acc0(7, 32'h20); step();
    chk("ovf before write-back", ovf, 0);
    chk("wrap ovf before write-back", w_ovf, 0);
    set_rd0(7, 32'h7FFF_FFFF, 32'h8000_0010); step();
    chk("ovf saturate", ovf, 1);
    chk("ovf wrap", w_ovf, 1);

    set_wr0(3, 32'd6); step();
    set_acc0(3, 32'd4); step();
    set_rd1(3, 32'd10);
    set_rd0(3, 32'd10, 32'd10);
    step();

    set_wr0(5, 32'hAA);
    set_wr1(5, 32'hBB);
    step();
    set_rd1(5, 32'hAA); step();

    set_acc0(9, 32'd1); step();
    set_wr0(9, 32'h55);
    set_wr1(9, 32'h66);
    step();
    set_rd0(9, 32'd1, 32'd1); step();

    set_acc0(2, 32'd100); step();
    clr_start = 1'b1; step();
    chk("busy on clr_start", busy, 1);
    chk("ovf cleared", ovf, 0);
    count_busy(5, n);
    chk("busy cycles after clr", n, 16);
    read_all_zero();
    chk("ovf after clear", ovf, 0);
    chk("wrap ovf after clear", w_ovf, 0);

    set_wr1(4, 32'h123); step();
    set_rd1(4, 32'h123);
    set_rd0(4, 32'h123, 32'h123);
    step();
    clr_start = 1'b1; step();
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    chk("busy in reset", busy, 1);
    chk("q0 in reset", q0, 0);
    chk("q1 in reset", q1, 0);
    #1;
    rst_n = 1'b1;
    count_busy(-1, n);
    chk("busy cycles after mid-clear reset", n, 16);
    read_all_zero();

    step();
    step();
    checks++;
    if (exp0.size() + exp1.size() + expw.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0",
               exp0.size() + exp1.size() + expw.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_acc_ram.md
# result_acc_ram

Parametrised dual-port result buffer for the sparse CNN datapath. Port 0 reads, writes, or performs a saturating read-modify-write accumulate of partial sums. Port 1 is a plain read/write port for result drain and host access. A built-in clear engine zeroes the array after reset and on request, and a sticky overflow flag reports saturation. It replaces the plain result RAM between the PE array and the output drain logic.

## Interface
- DWIDTH, 32: data width; signed two's complement for accumulate.
- AWIDTH, 4: address width.
- MEM_SIZE, 16: entries; must be <= 2^AWIDTH.
- SAT, 1: 1 = saturating add, 0 = wrap-around add.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr_start  in  1  single-cycle request to zero the array and clear ovf.
- busy  out  1  high while the clear engine runs; ports are ignored.
- ovf  out  1  sticky; set when any accumulate overflows.
- ce0  in  1  port 0 enable.
- op0  in  2  port 0 operation: 00 read, 01 write, 10 accumulate, 11 reserved (no-op).
- addr0  in  AWIDTH  port 0 address.
- d0  in  DWIDTH  port 0 write data or addend.
- q0  out  DWIDTH  port 0 read data.
- q0_valid  out  1  q0 updated this cycle.
- ce1  in  1  port 1 enable.
- we1  in  1  port 1 write (1) / read (0).
- addr1  in  AWIDTH  port 1 address.
- d1  in  DWIDTH  port 1 write data.
- q1  out  DWIDTH  port 1 read data.
- q1_valid  out  1  q1 updated this cycle.

## Operation
- Reset values: q0 = q1 = 0, q0_valid = q1_valid = 0, ovf = 0, busy = 1, clear counter = 0. RAM contents are not reset directly.
- Clear engine states:
  - IDLE -> CLEAR on clr_start while busy = 0, or on rst_n release.
  - CLEAR writes 0 to address cnt, one entry per cycle, cnt = 0..MEM_SIZE-1, then returns to IDLE and drops busy.
  - clr_start while busy is ignored.
  - Entering CLEAR clears ovf and flushes the accumulate pipeline.
  - Asserting rst_n mid-clear restarts the clear from address 0.
- While busy: ce0 and ce1 have no effect, and q*_valid stay 0.
- Port 0 read: q0 <= ram[addr0] (with forwarding, below); q0_valid = 1 for one cycle.
- Port 0 write: ram[addr0] <= d0 at the issue edge.
- Port 0 accumulate, 2-stage:
  - Issue edge T: capture addr0 and d0, and read the old value.
  - Edge T+1: write old + d0 to the captured address.
  - One accumulate can issue per cycle.
- Forwarding: if an issue targets the address held in the accumulate stage, that stage's result replaces the RAM value. This applies to port 0 accumulate, port 0 read, and port 1 read.
- Arithmetic: full DWIDTH+1 signed sum.
  - SAT = 1: clamp to 2^(DWIDTH-1)-1 or -2^(DWIDTH-1).
  - SAT = 0: keep the low DWIDTH bits.
  - In both modes, overflow sets ovf.
- Port 1: we1 = 1 writes d1; we1 = 0 reads, q1_valid = 1 for one cycle.
- Write collision priority, same address, same edge:
  - accumulate-stage write > port 0 write > port 1 write.
  - The losing write is dropped.
  - A port 0 write colliding with a pending accumulate write-back is dropped.
- Out-of-range addresses (>= MEM_SIZE): writes are ignored, and reads return 0 with valid asserted.

## Timing
- Read latency 1 on both ports: issue at edge T, q valid after edge T.
- q0 and q1 hold their last value while the corresponding valid is 0.
- Accumulate result is visible to any read issued at or after edge T+1 via forwarding; RAM is updated at T+1.
- busy stays high exactly MEM_SIZE cycles after reset release or an accepted clr_start.
  - After reset release, the first port access is accepted on edge MEM_SIZE+1.
- ovf updates at the write-back edge.

## Test plan
- Reset release -> busy high 16 cycles; afterwards port 1 reads of all addresses return 0 and ovf = 0.
- Port 0 accumulate addr 3 with d0 = 5, 7, -2 on back-to-back cycles, then read -> q0 = 10; no lost updates via forwarding.
- SAT = 1: write 0x7FFFFFF0, accumulate 0x20 -> 0x7FFFFFFF and ovf = 1. SAT = 0 build -> 0x80000010 and ovf = 1.
- Port 1 read of addr 3 on the cycle after accumulating 4 into value 6 -> q1 = 10.
- Same-edge port 0 write 0xAA and port 1 write 0xBB to addr 5 -> read returns 0xAA.
- clr_start mid-stream with a pending accumulate -> accumulate discarded, busy 16 cycles, all entries 0, ovf = 0; clr_start while busy has no effect; rst_n pulse at cnt = 8 restarts the clear from 0.
